// File: rtl/pio_cmd_receiver.sv
// rtl/pio_cmd_receiver.sv - toggle-strobe PIO command receiver with FIFO and valid/ready output
module pio_cmd_receiver #(
    parameter int DATA_W      = 7,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W:0]               pio_in,
    output logic [DATA_W-1:0]             cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          ack_toggle,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W:0]    w_pio_s;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_level;
    logic               r_prev_toggle;
    logic               r_ack;
    logic               r_ovf;
    logic               w_event;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Optional staging for a PIO driven from a foreign clock domain.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_pio_s = pio_in;
        end else begin : g_sync
            logic [DATA_W:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= pio_in;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_pio_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_event   = w_pio_s[DATA_W] ^ r_prev_toggle;
    assign w_full    = (r_level == FULL_LVL);
    assign w_pop     = cmd_valid && cmd_ready;
    // A pop frees a slot this cycle, so a full FIFO can still accept.
    assign w_push    = w_event && (!w_full || w_pop);
    assign w_drop    = w_event && w_full && !w_pop;

    assign cmd_valid  = (r_level != '0);
    assign cmd_data   = r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign ack_toggle = r_ack;
    assign overflow   = r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_prev_toggle <= 1'b0;
            r_ack         <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_prev_toggle <= w_pio_s[DATA_W];
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_pio_s[DATA_W-1:0];
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_ack           <= ~r_ack;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Drop takes priority over a simultaneous clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_cmd_receiver.sv
// tb/tb_pio_cmd_receiver.sv - table-driven bench with payload scoreboard for pio_cmd_receiver
module tb_pio_cmd_receiver;

    logic       clk;
    logic       reset_n;
    logic [7:0] pio_in;
    logic [6:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ack_toggle;
    logic       overflow;
    logic       clear_overflow;
    logic [2:0] fifo_level;

    pio_cmd_receiver #(.DATA_W(7), .FIFO_DEPTH(4), .SYNC_STAGES(0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_in         (pio_in),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .ack_toggle     (ack_toggle),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pio;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic       e_ack;
        logic       e_ovf;
        int         e_lvl;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] expq[$];
    logic       m_prev;
    int         m_level;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        expq.delete();
        m_prev  = 1'b0;
        m_level = 0;
    endtask

    // Reference model predicts which payloads enter the FIFO; drives one cycle.
    task automatic step(input logic [7:0] pio, input logic rdy, input logic clr);
        logic ev;
        logic pop;
        ev     = pio[7] ^ m_prev;
        m_prev = pio[7];
        pop    = (m_level > 0) && rdy;
        if (ev && (m_level < 4 || pop)) begin
            expq.push_back(pio[6:0]);
            m_level++;
        end
        if (pop) m_level--;
        pio_in         = pio;
        cmd_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (expq.size() == 0) begin
                chk("sb_unexpected_pop", 1, 0);
            end else begin
                chk("sb_cmd_data", int'(cmd_data), int'(expq.pop_front()));
            end
        end
    end

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{8'h85, 1, 0, 1, 1, 0, 1},
            '{8'h85, 1, 0, 0, 1, 0, 0},
            '{8'h03, 1, 0, 1, 0, 0, 1},
            '{8'h03, 1, 0, 0, 0, 0, 0},
            '{8'h85, 1, 0, 1, 1, 0, 1},
            '{8'h8A, 1, 0, 0, 1, 0, 0},
            '{8'h8A, 1, 0, 0, 1, 0, 0},
            '{8'h01, 0, 0, 1, 0, 0, 1},
            '{8'h82, 0, 0, 1, 1, 0, 2},
            '{8'h03, 0, 0, 1, 0, 0, 3},
            '{8'h84, 0, 0, 1, 1, 0, 4},
            '{8'h05, 0, 0, 1, 1, 1, 4},
            '{8'h05, 1, 0, 1, 1, 1, 3},
            '{8'h05, 1, 0, 1, 1, 1, 2},
            '{8'h05, 1, 0, 1, 1, 1, 1},
            '{8'h05, 1, 0, 0, 1, 1, 0},
            '{8'h05, 1, 1, 0, 1, 0, 0},
            '{8'h81, 0, 0, 1, 0, 0, 1},
            '{8'h02, 0, 0, 1, 1, 0, 2},
            '{8'h83, 0, 0, 1, 0, 0, 3},
            '{8'h04, 0, 0, 1, 1, 0, 4},
            '{8'h86, 1, 0, 1, 0, 0, 4},
            '{8'h86, 0, 0, 1, 0, 0, 4},
            '{8'h07, 0, 1, 1, 0, 1, 4},
            '{8'h07, 0, 0, 1, 0, 1, 4},
            '{8'h07, 1, 0, 1, 0, 1, 3}
        };

        reset_n        = 1'b0;
        pio_in         = 8'h00;
        cmd_ready      = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_data",  int'(cmd_data), 0);
        chk("rst_ack",   int'(ack_toggle), 0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_level", int'(fifo_level), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b1, 1'b0);
            chk("idle_valid", int'(cmd_valid), 0);
            chk("idle_ack",   int'(ack_toggle), 0);
        end
        chk("idle_ovf",   int'(overflow), 0);
        chk("idle_level", int'(fifo_level), 0);

        foreach (vecs[i]) begin
            step(vecs[i].pio, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d_valid", i), int'(cmd_valid),  int'(vecs[i].e_valid));
            chk($sformatf("v%0d_ack", i),   int'(ack_toggle), int'(vecs[i].e_ack));
            chk($sformatf("v%0d_ovf", i),   int'(overflow),   int'(vecs[i].e_ovf));
            chk($sformatf("v%0d_level", i), int'(fifo_level), vecs[i].e_lvl);
        end

        // Asynchronous reset with three commands still queued.
        chk("pre_rst_level", int'(fifo_level), 3);
        pio_in    = 8'h00;
        cmd_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("async_rst_valid", int'(cmd_valid), 0);
        chk("async_rst_level", int'(fifo_level), 0);
        chk("async_rst_ovf",   int'(overflow), 0);
        chk("async_rst_ack",   int'(ack_toggle), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b1, 1'b0);
            chk("post_rst_valid", int'(cmd_valid), 0);
            chk("post_rst_level", int'(fifo_level), 0);
            chk("post_rst_ack",   int'(ack_toggle), 0);
        end

        chk("sb_leftover", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
